fir_filter: RTL and testbench

Single-rate, direct-form FIR filter that processes one signed audio sample per clock. Coefficients are supplied as a port array, so one RTL block serves every equalizer band. Each band instance in the audio equalizer feeds the same input sample stream, and the equalizer applies per-band gain to the outputs.

---
 rtl/fir_pkg.sv | 32 +++
 rtl/fir_delay_line.sv | 25 ++
 rtl/fir_filter.sv | 51 +++++
 tb/tb_fir_filter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths and arithmetic helpers for the direct-form FIR
package fir_pkg;

    localparam int DEF_ORDER_FIR   = 64;
    localparam int DEF_COEFF_WIDTH = 32;
    localparam int DEF_INPUT_WIDTH = 24;

    // Working width for the saturate helper; any accumulator up to this size is handled.
    localparam int SAT_W = 128;

    function automatic int acc_width(input int input_width, input int coeff_width, input int order);
        return input_width + coeff_width + $clog2(order);
    endfunction

    function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] val,
                                                         input int out_width);
        logic signed [SAT_W-1:0] one;
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        one   = {{(SAT_W-1){1'b0}}, 1'b1};
        max_v = (one <<< (out_width - 1)) - one;
        min_v = ~max_v;
        if (val > max_v) begin
            return max_v;
        end
        if (val < min_v) begin
            return min_v;
        end
        return val;
    endfunction

endpackage

// File: rtl/fir_delay_line.sv
// rtl/fir_delay_line.sv - sample shift register feeding the FIR taps, newest sample at taps[0]
module fir_delay_line #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] din,
    output logic signed [WIDTH-1:0] taps [DEPTH]
);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                taps[k] <= '0;
            end
        end else begin
            taps[0] <= din;
            for (int k = 1; k < DEPTH; k++) begin
                taps[k] <= taps[k-1];
            end
        end
    end

endmodule

// File: rtl/fir_filter.sv
// rtl/fir_filter.sv - single-rate direct-form FIR: full-precision MAC, floor scaling, saturation
module fir_filter
    import fir_pkg::*;
#(
    parameter int ORDER_FIR    = DEF_ORDER_FIR,
    parameter int COEFF_WIDTH  = DEF_COEFF_WIDTH,
    parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
    parameter int OUTPUT_WIDTH = INPUT_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic signed [INPUT_WIDTH-1:0]  data_in,
    input  logic signed [COEFF_WIDTH-1:0]  h [ORDER_FIR],
    output logic signed [OUTPUT_WIDTH-1:0] data_out
);

    localparam int ACC_W = acc_width(INPUT_WIDTH, COEFF_WIDTH, ORDER_FIR);

    logic signed [INPUT_WIDTH-1:0] x [ORDER_FIR];
    logic signed [ACC_W-1:0]       acc;
    logic signed [ACC_W-1:0]       scaled;

    fir_delay_line #(
        .DEPTH (ORDER_FIR),
        .WIDTH (INPUT_WIDTH)
    ) u_delay_line (
        .clk   (clk),
        .reset (reset),
        .din   (data_in),
        .taps  (x)
    );

    // Both operands are sign-extended to the accumulator width, so every product and sum is exact.
    always_comb begin
        acc = '0;
        for (int k = 0; k < ORDER_FIR; k++) begin
            acc = acc + ACC_W'(h[k]) * ACC_W'(x[k]);
        end
    end

    assign scaled = acc >>> (COEFF_WIDTH - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= '0;
        end else begin
            data_out <= OUTPUT_WIDTH'(saturate(SAT_W'(scaled), OUTPUT_WIDTH));
        end
    end

endmodule

// File: tb/tb_fir_filter.sv
// tb/tb_fir_filter.sv - randomized and directed bench for fir_filter against a convolution model
module tb_fir_filter;

    localparam int N  = 64;
    localparam int CW = 32;
    localparam int IW = 24;
    localparam longint OUT_MAX = 64'sd8388607;
    localparam longint OUT_MIN = -64'sd8388608;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic signed [IW-1:0] data_in = '0;
    logic signed [CW-1:0] h [N];
    logic signed [IW-1:0] data_out;

    int vectors = 0;
    int miscompares = 0;
    int hist [$];
    longint expected = 0;

    fir_filter #(
        .ORDER_FIR    (N),
        .COEFF_WIDTH  (CW),
        .INPUT_WIDTH  (IW),
        .OUTPUT_WIDTH (IW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .h        (h),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // y[n] = sat(floor(sum h[k]*s[n-1-k] / 2^31)), over samples received since the last reset.
    function automatic longint model_out();
        longint acc = 0;
        longint y;
        for (int k = 0; k < N && k < hist.size(); k++) begin
            acc += longint'(h[k]) * longint'(hist[k]);
        end
        y = acc >>> (CW - 1);
        if (y > OUT_MAX) return OUT_MAX;
        if (y < OUT_MIN) return OUT_MIN;
        return y;
    endfunction

    task automatic tick(input string tag, input logic signed [IW-1:0] din, input logic rst);
        data_in = din;
        reset   = rst;
        @(posedge clk);
        if (rst) begin
            expected = 0;
            hist.delete();
        end else begin
            expected = model_out();
            hist.push_front(int'(din));
        end
        @(negedge clk);
        check(tag, longint'(data_out), expected);
    endtask

    task automatic set_all_h(input logic signed [CW-1:0] v);
        for (int k = 0; k < N; k++) h[k] = v;
    endtask

    initial begin
        set_all_h('0);
        h[0] = 32'sh4000_0000;

        // Startup reset with live input must leave no history behind.
        for (int i = 0; i < 3; i++) tick("startup_rst", 24'sd77777, 1'b1);
        tick("post_rst0", 24'sd1000, 1'b0);
        tick("post_rst1", 24'sd0, 1'b0);
        check("post_rst_const", longint'(data_out), 64'sd500);

        // Impulse through h[0]=0.5.
        tick("rst", 24'sd0, 1'b1);
        tick("imp", 24'sd1000, 1'b0);
        check("imp_lat1", longint'(data_out), 64'sd0);
        tick("imp", 24'sd0, 1'b0);
        check("imp_500", longint'(data_out), 64'sd500);
        for (int i = 0; i < 4; i++) tick("imp_tail", 24'sd0, 1'b0);
        check("imp_zero", longint'(data_out), 64'sd0);

        // Impulse response readout: h[k] = k/128 gives 2k per cycle.
        for (int k = 0; k < N; k++) h[k] = CW'(k * 32'sh0100_0000);
        tick("rst", 24'sd0, 1'b1);
        tick("ramp_in", 24'sh000100, 1'b0);
        for (int k = 0; k < N; k++) begin
            tick("ramp", 24'sd0, 1'b0);
            check("ramp_const", longint'(data_out), longint'(2 * k));
        end
        tick("ramp_end", 24'sd0, 1'b0);
        check("ramp_end_const", longint'(data_out), 64'sd0);

        // Floor, not round-to-nearest, for negative values.
        set_all_h('0);
        h[0] = 32'sh4000_0000;
        tick("rst", 24'sd0, 1'b1);
        for (int i = 0; i < 4; i++) tick("floor", -24'sd3, 1'b0);
        check("floor_const", longint'(data_out), -64'sd2);

        // Saturation at both rails.
        set_all_h(32'sh7FFF_FFFF);
        tick("rst", 24'sd0, 1'b1);
        for (int i = 0; i < N + 4; i++) tick("sat_hi", 24'sh7FFFFF, 1'b0);
        check("sat_hi_const", longint'(data_out), OUT_MAX);
        for (int i = 0; i < N + 4; i++) tick("sat_lo", 24'sh800000, 1'b0);
        check("sat_lo_const", longint'(data_out), OUT_MIN);

        // -1.0 coefficient against the most negative sample overflows positive and saturates.
        set_all_h('0);
        h[0] = 32'sh8000_0000;
        tick("rst", 24'sd0, 1'b1);
        for (int i = 0; i < 3; i++) tick("neg1", 24'sh800000, 1'b0);
        check("neg1_const", longint'(data_out), OUT_MAX);
        for (int i = 0; i < 3; i++) tick("neg1b", 24'sd1234, 1'b0);
        check("neg1b_const", longint'(data_out), -64'sd1234);

        // Mid-stream reset discards the step history.
        set_all_h('0);
        for (int k = 0; k < 4; k++) h[k] = 32'sh2000_0000;
        tick("rst", 24'sd0, 1'b1);
        for (int i = 0; i < 8; i++) tick("step", 24'sd5000, 1'b0);
        check("step_full", longint'(data_out), 64'sd5000);
        tick("mid_rst", 24'sd5000, 1'b1);
        check("mid_rst_zero", longint'(data_out), 64'sd0);
        tick("step2", 24'sd5000, 1'b0);
        check("step2_0", longint'(data_out), 64'sd0);
        for (int i = 1; i <= 4; i++) begin
            tick("step2", 24'sd5000, 1'b0);
            check("step2_ramp", longint'(data_out), longint'(1250 * i));
        end

        // Randomized segments: small coefficients (linear region), then full-range ones.
        for (int seg = 0; seg < 4; seg++) begin
            for (int k = 0; k < N; k++) begin
                if (seg < 2) h[k] = CW'($signed($urandom) >>> 7);
                else if ($urandom_range(0, 15) == 0) h[k] = 32'sh8000_0000;
                else h[k] = CW'($urandom);
            end
            tick("rst", 24'sd0, 1'b1);
            for (int i = 0; i < 250; i++) begin
                if ($urandom_range(0, 99) == 0) tick("rnd_rst", IW'($urandom), 1'b1);
                else if ($urandom_range(0, 19) == 0) tick("rnd_ext", ($urandom_range(0, 1) != 0) ? 24'sh7FFFFF : 24'sh800000, 1'b0);
                else tick("rnd", IW'($urandom), 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
